ntsc_chroma_mod: RTL and testbench

4fsc NTSC composite encoder stage, directly downstream of the RGB-to-YUV converter. Consumes 8-bit Y and 8-bit two's-complement U/V at 4fsc. Quadrature-modulates U/V onto the subcarrier using the sample sequence +U, +V, -U, -V. Adds scaled luma, blank pedestal, sync tip and colour burst, and produces a clamped 10-bit unsigned composite sample stream for the video DAC.

---
 rtl/ntsc_chroma_mod.sv | 118 +++++++++++
 tb/tb_ntsc_chroma_mod.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ntsc_chroma_mod.sv
`default_nettype none
// ============================================================================
// Module   : ntsc_chroma_mod
// Function : 4fsc NTSC composite encoder; quadrature chroma, luma, sync, burst
// Revision : 1.0
// ============================================================================
module ntsc_chroma_mod #(
    parameter int C_BLANK     = 256,
    parameter int C_BURST_AMP = 128
) (
    input  logic       CK_i,
    input  logic       AR_i,
    input  logic       CK_EE_i,
    input  logic       PHASE_RST_i,
    input  logic [7:0] YYs_i,
    input  logic [7:0] UUs_i,
    input  logic [7:0] VVs_i,
    input  logic       SYNC_i,
    input  logic       BLANK_i,
    input  logic       BURST_i,
    output logic [9:0] VIDEOs_o,
    output logic [1:0] PHASE_o
);

    localparam logic signed [11:0] c_blank = 12'(C_BLANK);
    localparam logic signed [11:0] c_burst = 12'(C_BURST_AMP);

    logic [1:0]         r_phase;
    logic [1:0]         w_cur_phase;
    logic [9:0]         w_luma;
    logic signed [10:0] w_u_ext;
    logic signed [10:0] w_v_ext;
    logic signed [10:0] w_sel;
    logic signed [10:0] w_chroma;

    logic [9:0]         r_luma;
    logic signed [10:0] r_chroma;
    logic               r_sync;
    logic               r_blank;
    logic               r_burst;
    logic [1:0]         r_ph1;
    logic               r_valid1;

    logic signed [11:0] w_burst;
    logic signed [11:0] w_level;
    logic [9:0]         w_video;

    // A phase reset forces the captured sample to phase 0 and preloads 1.
    assign w_cur_phase = PHASE_RST_i ? 2'd0 : r_phase;
    assign w_luma      = {1'b0, YYs_i, 1'b0} + {3'b000, YYs_i[7:1]};
    assign w_u_ext     = {{3{UUs_i[7]}}, UUs_i};
    assign w_v_ext     = {{3{VVs_i[7]}}, VVs_i};
    assign w_sel       = w_cur_phase[0] ? w_v_ext : w_u_ext;
    assign w_chroma    = (w_cur_phase[1] ? -w_sel : w_sel) <<< 1;

    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            r_phase  <= 2'd0;
            r_luma   <= '0;
            r_chroma <= '0;
            r_sync   <= 1'b0;
            r_blank  <= 1'b0;
            r_burst  <= 1'b0;
            r_ph1    <= 2'd0;
            r_valid1 <= 1'b0;
        end else if (CK_EE_i) begin
            r_phase  <= w_cur_phase + 2'd1;
            r_luma   <= w_luma;
            r_chroma <= w_chroma;
            r_sync   <= SYNC_i;
            r_blank  <= BLANK_i;
            r_burst  <= BURST_i;
            r_ph1    <= w_cur_phase;
            r_valid1 <= 1'b1;
        end
    end

    // Burst sits 180 degrees from +U.
    always_comb begin
        w_burst = 12'sd0;
        case (r_ph1)
            2'd0:    w_burst = -c_burst;
            2'd2:    w_burst = c_burst;
            default: w_burst = 12'sd0;
        endcase
    end

    always_comb begin
        w_level = 12'sd0;
        if (r_sync) begin
            w_level = 12'sd0;
        end else if (r_blank) begin
            w_level = r_burst ? (c_blank + w_burst) : c_blank;
        end else begin
            w_level = c_blank + $signed({2'b00, r_luma}) + $signed({r_chroma[10], r_chroma});
        end
        if (w_level < 12'sd0) begin
            w_video = 10'd0;
        end else if (w_level > 12'sd1023) begin
            w_video = 10'd1023;
        end else begin
            w_video = w_level[9:0];
        end
    end

    // Until stage 1 holds a real sample, the output stays at 0.
    always_ff @(posedge CK_i or posedge AR_i) begin
        if (AR_i) begin
            VIDEOs_o <= '0;
            PHASE_o  <= 2'd0;
        end else if (CK_EE_i) begin
            VIDEOs_o <= r_valid1 ? w_video : 10'd0;
            PHASE_o  <= r_ph1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntsc_chroma_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntsc_chroma_mod
// Function : Self-checking bench for ntsc_chroma_mod against a sample model
// Revision : 1.0
// ============================================================================
module tb_ntsc_chroma_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ck_ee = 1'b0;
    logic       phase_rst = 1'b0;
    logic [7:0] yy = '0;
    logic [7:0] uu = '0;
    logic [7:0] vv = '0;
    logic       sync = 1'b0;
    logic       blank = 1'b0;
    logic       burst = 1'b0;
    logic [9:0] video;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;

    // Model state: next phase, samples in flight, current expected output.
    int m_phase = 0;
    int q_video[$];
    int q_phase[$];
    int exp_video = 0;
    int exp_phase = 0;

    ntsc_chroma_mod #(.C_BLANK(256), .C_BURST_AMP(128)) dut (
        .CK_i        (clk),
        .AR_i        (rst),
        .CK_EE_i     (ck_ee),
        .PHASE_RST_i (phase_rst),
        .YYs_i       (yy),
        .UUs_i       (uu),
        .VVs_i       (vv),
        .SYNC_i      (sync),
        .BLANK_i     (blank),
        .BURST_i     (burst),
        .VIDEOs_o    (video),
        .PHASE_o     (phase)
    );

    always #5 clk = ~clk;

    function automatic int ref_video(input int y, input int u, input int v,
                                     input bit s, input bit bl, input bit bu, input int p);
        int c;
        int val;
        if (s) return 0;
        if (bl) begin
            if (!bu) return 256;
            return (p == 0) ? 128 : (p == 2) ? 384 : 256;
        end
        case (p)
            0: c = u;
            1: c = v;
            2: c = -u;
            default: c = -v;
        endcase
        val = 256 + y * 2 + y / 2 + c * 2;
        if (val < 0) val = 0;
        if (val > 1023) val = 1023;
        return val;
    endfunction

    task automatic model_clear();
        m_phase = 0;
        q_video.delete();
        q_phase.delete();
        exp_video = 0;
        exp_phase = 0;
    endtask

    // One clock: drive, clock, update model, compare.
    task automatic step(input bit en, input bit prst, input int y, input int u, input int v,
                        input bit s, input bit bl, input bit bu, input string name);
        int p;
        ck_ee = en; phase_rst = prst;
        yy = 8'(y); uu = 8'(u); vv = 8'(v);
        sync = s; blank = bl; burst = bu;
        @(posedge clk);
        #1;
        if (en) begin
            p = prst ? 0 : m_phase;
            m_phase = (p + 1) % 4;
            q_video.push_back(ref_video(y, u, v, s, bl, bu, p));
            q_phase.push_back(p);
            if (q_video.size() == 2) begin
                exp_video = q_video.pop_front();
                exp_phase = q_phase.pop_front();
            end
        end
        checks++;
        if (int'(video) !== exp_video || int'(phase) !== exp_phase) begin
            errors++;
            $display("FAIL %s: video=%0d phase=%0d expected video=%0d phase=%0d",
                     name, video, phase, exp_video, exp_phase);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (video !== 10'd0 || phase !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: video=%0d phase=%0d expected 0/0", video, phase);
        end
        rst = 1'b0;
        model_clear();
        step(1'b1, 1'b0, 100, 20, -10, 1'b0, 1'b0, 1'b0, "post_reset_first");
    endtask

    task automatic test_active();
        int exp_v[4] = '{546, 486, 466, 526};
        step(1'b1, 1'b1, 100, 20, -10, 1'b0, 1'b0, 1'b0, "active_prst");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 100, 20, -10, 1'b0, 1'b0, 1'b0, "active");
            checks++;
            if (int'(video) !== exp_v[i % 4] || int'(phase) !== i % 4) begin
                errors++;
                $display("FAIL active_const: video=%0d phase=%0d expected video=%0d phase=%0d",
                         video, phase, exp_v[i % 4], i % 4);
            end
        end
    endtask

    task automatic test_sync();
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, $urandom_range(255), $urandom_range(255) - 128,
                 $urandom_range(255) - 128, 1'b1, i[0], i[1], "sync");
    endtask

    task automatic test_blank_burst();
        step(1'b1, 1'b1, 50, 30, 30, 1'b0, 1'b1, 1'b1, "burst_prst");
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 50, 30, 30, 1'b0, 1'b1, 1'b1, "burst");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 200, -60, 90, 1'b0, 1'b1, 1'b0, "blank");
    endtask

    task automatic test_clamp();
        step(1'b1, 1'b1, 255, 127, 0, 1'b0, 1'b0, 1'b0, "clamp_hi");
        step(1'b1, 1'b0, 0, -128, 0, 1'b0, 1'b0, 1'b0, "clamp_p1");
        step(1'b1, 1'b0, 0, -128, 0, 1'b0, 1'b0, 1'b0, "clamp_neg_u");
        step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, "clamp_p3");
        step(1'b1, 1'b1, 0, -128, 0, 1'b0, 1'b0, 1'b0, "clamp_lo");
        step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, "clamp_flush");
    endtask

    task automatic test_clock_enable();
        bit en_pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++)
            step(en_pat[i], !en_pat[i], 30 * i, 10 * i - 40, 40 - 7 * i,
                 1'b0, 1'b0, 1'b0, "clock_enable");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 120, 50, -50, 1'b0, 1'b0, 1'b0, "pre_async");
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (video !== 10'd0 || phase !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: video=%0d phase=%0d expected 0/0", video, phase);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 120, 50, -50, 1'b0, 1'b0, 1'b0, "post_async");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            step(($urandom_range(7) != 0), ($urandom_range(15) == 0),
                 $urandom_range(255), $urandom_range(255) - 128, $urandom_range(255) - 128,
                 ($urandom_range(9) == 0), ($urandom_range(4) == 0), $urandom_range(1) == 1,
                 "random");
    endtask

    initial begin
        test_reset();
        test_active();
        test_sync();
        test_blank_burst();
        test_clamp();
        test_clock_enable();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
